nibble_serial_add_ctrl: RTL and testbench

//   Sequencer that performs a WIDTH-bit addition by time-multiplexing one

---
 rtl/nibble_serial_add_ctrl_if.sv | 25 ++
 rtl/nibble_serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder controller.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;

  // Producer/consumer side
  modport master (
    output in_valid, op_a, op_b, cin, out_ready,
    input  in_ready, out_valid, sum
  );

  // Controller side
  modport slave (
    input  in_valid, op_a, op_b, cin, out_ready,
    output in_ready, out_valid, sum
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences a WIDTH-bit add through one external 4-bit adder slice,
// LSB nibble first, chaining the carry through a register.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nibble_serial_add_ctrl_if.slave  bus,
  output logic                     busy,
  output logic [3:0]               add_a,
  output logic [3:0]               add_b,
  output logic                     add_c,
  input  logic [4:0]               add_sum
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH:0]   sum_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // Result with the current slice output merged into nibble cnt
  always_comb begin
    res_d = res_q;
    if (state_q == S_RUN) begin
      res_d[4*int'(cnt_q) +: 4] = add_sum[3:0];
    end
  end

  // Control FSM and datapath registers; shift regs drain to zero and the
  // carry is cleared on the last nibble so slice inputs are 0 outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_sh_q     <= bus.op_a;
            b_sh_q     <= bus.op_b;
            carry_q    <= bus.cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          res_q   <= res_d;
          carry_q <= add_sum[4];
          a_sh_q  <= a_sh_q >> 4;
          b_sh_q  <= b_sh_q >> 4;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(NIB - 1)) begin
            sum_q       <= {add_sum[4], res_d};
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign busy          = busy_q;
  assign add_a         = a_sh_q[3:0];
  assign add_b         = b_sh_q[3:0];
  assign add_c         = carry_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized self-checking bench for nibble_serial_add_ctrl (WIDTH=16 and 4).
module tb_nibble_serial_add_ctrl;

  localparam int unsigned NIB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.WIDTH(16)) bus16 ();
  nibble_serial_add_ctrl_if #(.WIDTH(4))  bus4 ();

  logic       busy16, busy4;
  logic [3:0] a16, b16, a4, b4;
  logic       c16, c4;
  logic [4:0] s16, s4;

  // External 4-bit full-adder slices
  assign s16 = 5'(a16) + 5'(b16) + 5'(c16);
  assign s4  = 5'(a4) + 5'(b4) + 5'(c4);

  nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16),
    .busy(busy16), .add_a(a16), .add_b(b16), .add_c(c16), .add_sum(s16)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4),
    .busy(busy4), .add_a(a4), .add_b(b4), .add_c(c4), .add_sum(s4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full 16-bit operation with per-cycle slice checks and optional backpressure
  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input int hold);
    logic [31:0] exp;
    logic [31:0] mask;
    int          waits;
    exp   = 32'(a) + 32'(b) + 32'(c);
    waits = 0;
    bus16.op_a = a; bus16.op_b = b; bus16.cin = c; bus16.in_valid = 1'b1;
    while (!bus16.in_ready && waits < 20) begin
      step();
      waits++;
    end
    chk("accept_wait", 32'(waits < 20), 32'd1);
    step();
    bus16.in_valid = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      mask = (32'd1 << (4 * i)) - 32'd1;
      chk("run_busy", 32'(busy16), 32'd1);
      chk("run_in_ready", 32'(bus16.in_ready), 32'd0);
      chk("run_out_valid", 32'(bus16.out_valid), 32'd0);
      chk("run_add_a", 32'(a16), (32'(a) >> (4 * i)) & 32'hF);
      chk("run_add_b", 32'(b16), (32'(b) >> (4 * i)) & 32'hF);
      chk("run_add_c", 32'(c16), ((32'(a) & mask) + (32'(b) & mask) + 32'(c)) >> (4 * i));
      step();
    end
    chk("done_out_valid", 32'(bus16.out_valid), 32'd1);
    chk("done_sum", 32'(bus16.sum), exp);
    chk("done_add_a", 32'(a16), 32'd0);
    chk("done_add_c", 32'(c16), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus16.in_valid = 1'($urandom_range(0, 1));
      bus16.op_a     = 16'($urandom);
      step();
      chk("bp_out_valid", 32'(bus16.out_valid), 32'd1);
      chk("bp_sum", 32'(bus16.sum), exp);
      chk("bp_in_ready", 32'(bus16.in_ready), 32'd0);
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    step();
    bus16.out_ready = 1'b0;
    chk("idle_out_valid", 32'(bus16.out_valid), 32'd0);
    chk("idle_in_ready", 32'(bus16.in_ready), 32'd1);
    chk("idle_busy", 32'(busy16), 32'd0);
    chk("idle_sum_hold", 32'(bus16.sum), exp);
  endtask

  // One 4-bit operation: a single RUN cycle
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                     input logic [4:0] exp);
    bus4.op_a = a; bus4.op_b = b; bus4.cin = c; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    chk("w4_add_a", 32'(a4), 32'(a));
    chk("w4_add_c", 32'(c4), 32'(c));
    step();
    chk("w4_out_valid", 32'(bus4.out_valid), 32'd1);
    chk("w4_sum", 32'(bus4.sum), 32'(exp));
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    chk("w4_idle", 32'(bus4.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb, ra2, rb2;
    logic        rc, rc2;
    logic [3:0]  x, y;
    logic        z;

    bus16.in_valid = 1'b0; bus16.op_a = '0; bus16.op_b = '0; bus16.cin = 1'b0;
    bus16.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.cin = 1'b0;
    bus4.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    chk("rst_sum", 32'(bus16.sum), 32'd0);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_add", 32'({a16, b16, c16}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(bus16.in_ready), 32'd1);

    // Directed cases
    do_op16(16'h00FF, 16'h0001, 1'b0, 0);
    chk("t1_sum", 32'(bus16.sum), 32'h00100);
    do_op16(16'hFFFF, 16'hFFFF, 1'b1, 0);
    chk("t2_sum", 32'(bus16.sum), 32'h1FFFF);
    do_op16(16'hA5C3, 16'h5A3D, 1'b1, 5);

    // Reset in the second RUN cycle discards the add
    bus16.op_a = 16'h1234; bus16.op_b = 16'h4321; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus16.out_valid), 32'd0);
    chk("mid_rst_sum", 32'(bus16.sum), 32'd0);
    chk("mid_rst_add", 32'({a16, b16, c16}), 32'd0);
    chk("mid_rst_busy", 32'(busy16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mid_rst_in_ready", 32'(bus16.in_ready), 32'd1);
    do_op16(16'h0005, 16'h0003, 1'b0, 0);
    chk("t4_sum", 32'(bus16.sum), 32'h00008);

    // Back-to-back with in_valid and out_ready held high
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
    ra2 = 16'($urandom); rb2 = 16'($urandom); rc2 = 1'($urandom_range(0, 1));
    bus16.out_ready = 1'b1;
    bus16.op_a = ra; bus16.op_b = rb; bus16.cin = rc; bus16.in_valid = 1'b1;
    step();
    bus16.op_a = ra2; bus16.op_b = rb2; bus16.cin = rc2;
    repeat (NIB) step();
    chk("b2b_valid1", 32'(bus16.out_valid), 32'd1);
    chk("b2b_sum1", 32'(bus16.sum), 32'(ra) + 32'(rb) + 32'(rc));
    step();
    chk("b2b_hs1", 32'(bus16.out_valid), 32'd0);
    chk("b2b_idle_busy", 32'(busy16), 32'd0);
    step();
    chk("b2b_accept2", 32'(busy16), 32'd1);
    bus16.in_valid = 1'b0;
    repeat (NIB) step();
    chk("b2b_valid2", 32'(bus16.out_valid), 32'd1);
    chk("b2b_sum2", 32'(bus16.sum), 32'(ra2) + 32'(rb2) + 32'(rc2));
    step();
    chk("b2b_hs2", 32'(bus16.out_valid), 32'd0);
    bus16.out_ready = 1'b0;

    // Random operands with random backpressure
    for (int k = 0; k < 30; k++) begin
      do_op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));
    end

    // WIDTH=4 instance
    op4(4'd4, 4'd5, 1'b1, 5'h0A);
    op4(4'd15, 4'd15, 1'b1, 5'h1F);
    for (int k = 0; k < 10; k++) begin
      x = 4'($urandom); y = 4'($urandom); z = 1'($urandom_range(0, 1));
      op4(x, y, z, 5'(5'(x) + 5'(y) + 5'(z)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
